// File: rtl/pll_reset_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pll_rstctrl_pkg
// Purpose  : Shared state encoding, counter sizing and widths for pll_reset_ctrl
// Revision : 1.0 - initial release
// ============================================================================
package pll_rstctrl_pkg;

  localparam int LOSS_CNT_W = 16;

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } pll_rstctrl_state_t;

  // Width of the shared phase counter, sized for the longest phase.
  function automatic int cnt_width(input int rst, input int timeout, input int stable);
    int m;
    m = rst;
    if (timeout > m) m = timeout;
    if (stable > m) m = stable;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pll_reset_ctrl_sync_2ff.sv
`default_nettype none
// ============================================================================
// Module   : sync_2ff
// Purpose  : Two-flop synchronizer with synchronous active-high reset to 0
// Revision : 1.0 - initial release
// ============================================================================
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/pll_reset_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pll_reset_ctrl
// Purpose  : PLL reset/lock handshake with timeout retries and a lock-qualified
//            downstream reset. Define PLL_RSTCTRL_LOSS_CNT_EN to enable the
//            saturating lock-loss event counter.
// Revision : 1.0 - initial release
// ============================================================================
module pll_reset_ctrl
  import pll_rstctrl_pkg::*;
#(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 7,
  parameter int RETRY_W       = 4
) (
  input  logic                  refclk,
  input  logic                  rst,
  input  logic                  locked,
  output logic                  pll_rst,
  output logic                  sys_rst,
  output logic                  lock_ok,
  output logic                  fail,
  output logic [RETRY_W-1:0]    retry_cnt,
  output logic [LOSS_CNT_W-1:0] loss_cnt
);

  localparam int CNT_W = cnt_width(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam logic [CNT_W-1:0]   RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TO_LAST     = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRIES);

  pll_rstctrl_state_t state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [RETRY_W-1:0] retry_q;
  logic               pll_rst_q, sys_rst_q, lock_ok_q, fail_q;
  logic               locked_s;

  sync_2ff #(.W(1)) u_lock_sync (
    .clk_i (refclk),
    .rst_i (rst),
    .d_i   (locked),
    .q_o   (locked_s)
  );

  // Outputs are loaded with the decode of the state being entered.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q   <= RESET_PLL;
      cnt_q     <= '0;
      retry_q   <= '0;
      pll_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      lock_ok_q <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      case (state_q)
        RESET_PLL: begin
          if (cnt_q == RST_LAST) begin
            state_q   <= WAIT_LOCK;
            cnt_q     <= '0;
            pll_rst_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        WAIT_LOCK: begin
          if (locked_s) begin
            state_q <= STABLE;
            cnt_q   <= '0;
          end else if (cnt_q == TO_LAST) begin
            cnt_q     <= '0;
            pll_rst_q <= 1'b1;
            if (retry_q == RETRY_MAX) begin
              state_q <= FAIL;
              fail_q  <= 1'b1;
            end else begin
              state_q <= RESET_PLL;
              retry_q <= retry_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        STABLE: begin
          if (!locked_s) begin
            state_q <= WAIT_LOCK;
            cnt_q   <= '0;
          end else if (cnt_q == STABLE_LAST) begin
            state_q   <= RUN;
            sys_rst_q <= 1'b0;
            lock_ok_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RUN: begin
          if (!locked_s) begin
            state_q   <= RESET_PLL;
            cnt_q     <= '0;
            retry_q   <= '0;
            pll_rst_q <= 1'b1;
            sys_rst_q <= 1'b1;
            lock_ok_q <= 1'b0;
          end
        end
        FAIL: begin
          state_q <= FAIL;
        end
        default: begin
          state_q   <= RESET_PLL;
          cnt_q     <= '0;
          pll_rst_q <= 1'b1;
          sys_rst_q <= 1'b1;
          lock_ok_q <= 1'b0;
          fail_q    <= 1'b0;
        end
      endcase
    end
  end

  assign pll_rst   = pll_rst_q;
  assign sys_rst   = sys_rst_q;
  assign lock_ok   = lock_ok_q;
  assign fail      = fail_q;
  assign retry_cnt = retry_q;

`ifdef PLL_RSTCTRL_LOSS_CNT_EN
  logic [LOSS_CNT_W-1:0] loss_q, loss_d;

  always_comb begin
    loss_d = loss_q;
    if (state_q == RUN && !locked_s && loss_q != '1) loss_d = loss_q + 1'b1;
  end

  always_ff @(posedge refclk) begin
    if (rst) loss_q <= '0;
    else     loss_q <= loss_d;
  end

  assign loss_cnt = loss_q;
`else
  assign loss_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pll_reset_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pll_reset_ctrl
// Purpose  : Self-checking bench for pll_reset_ctrl: directed vector table plus
//            randomized lock patterns against a phase-level reference model
// Revision : 1.0 - initial release
// ============================================================================
module tb_pll_reset_ctrl;

  localparam int RSTC = 4, TOUT = 20, STC = 8, MAXR = 2;
`ifdef PLL_RSTCTRL_LOSS_CNT_EN
  localparam int LOSS_EN = 1;
`else
  localparam int LOSS_EN = 0;
`endif
  localparam int PH_RESET = 0, PH_WAIT = 1, PH_STABLE = 2, PH_RUN = 3, PH_DEAD = 4;

  logic        refclk = 1'b0;
  logic        rst, locked;
  logic        pll_rst, sys_rst, lock_ok, fail;
  logic [3:0]  retry_cnt;
  logic [15:0] loss_cnt;

  int checks = 0, failures = 0;

  pll_reset_ctrl #(
    .RST_CYCLES(RSTC), .LOCK_TIMEOUT(TOUT), .STABLE_CYCLES(STC),
    .MAX_RETRIES(MAXR), .RETRY_W(4)
  ) dut (
    .refclk(refclk), .rst(rst), .locked(locked), .pll_rst(pll_rst),
    .sys_rst(sys_rst), .lock_ok(lock_ok), .fail(fail),
    .retry_cnt(retry_cnt), .loss_cnt(loss_cnt)
  );

  always #5 refclk = ~refclk;

  // Reference model: current phase, cycles spent in it, and the raw lock
  // history the controller can see two edges late.
  int m_ph = PH_RESET, m_age = 0, m_retry = 0, m_loss = 0;
  bit hist[$] = '{1'b0, 1'b0};

  task automatic model_step(input bit r, input bit lk);
    bit seen;
    if (r) begin
      m_ph = PH_RESET; m_age = 0; m_retry = 0; m_loss = 0;
      hist = '{1'b0, 1'b0};
      return;
    end
    seen = hist.pop_front();
    hist.push_back(lk);
    m_age++;
    case (m_ph)
      PH_RESET:  if (m_age == RSTC) begin m_ph = PH_WAIT; m_age = 0; end
      PH_WAIT: begin
        if (seen) begin m_ph = PH_STABLE; m_age = 0; end
        else if (m_age == TOUT) begin
          m_age = 0;
          if (m_retry == MAXR) m_ph = PH_DEAD;
          else begin m_retry++; m_ph = PH_RESET; end
        end
      end
      PH_STABLE: begin
        if (!seen) begin m_ph = PH_WAIT; m_age = 0; end
        else if (m_age == STC) begin m_ph = PH_RUN; m_age = 0; end
      end
      PH_RUN: if (!seen) begin
        m_ph = PH_RESET; m_age = 0; m_retry = 0;
        if (LOSS_EN != 0 && m_loss < 65535) m_loss++;
      end
      default: ;
    endcase
  endtask

  task automatic check_model();
    bit e_pll, e_sys, e_ok, e_fail;
    e_pll  = (m_ph == PH_RESET) || (m_ph == PH_DEAD);
    e_sys  = (m_ph != PH_RUN);
    e_ok   = (m_ph == PH_RUN);
    e_fail = (m_ph == PH_DEAD);
    checks++;
    if (pll_rst !== e_pll || sys_rst !== e_sys || lock_ok !== e_ok || fail !== e_fail ||
        retry_cnt !== 4'(m_retry) || loss_cnt !== 16'(m_loss)) begin
      failures++;
      $display("FAIL model t=%0t got pll=%b sys=%b ok=%b fail=%b retry=%0d loss=%0d want pll=%b sys=%b ok=%b fail=%b retry=%0d loss=%0d",
               $time, pll_rst, sys_rst, lock_ok, fail, retry_cnt, loss_cnt,
               e_pll, e_sys, e_ok, e_fail, m_retry, m_loss);
    end
  endtask

  task automatic cycle(input bit r, input bit lk);
    rst = r; locked = lk;
    @(posedge refclk);
    model_step(r, lk);
    #1;
    check_model();
  endtask

  typedef struct {
    bit r; bit lk; int n;
    bit pll; bit sys; bit ok; bit fl; int retry; int loss;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input bit r, input bit lk, input int n, input bit pll, input bit sys,
                     input bit ok, input bit fl, input int retry, input int loss);
    vec_t v;
    v.r = r; v.lk = lk; v.n = n; v.pll = pll; v.sys = sys; v.ok = ok; v.fl = fl;
    v.retry = retry; v.loss = loss * LOSS_EN;
    tbl.push_back(v);
  endtask

  initial begin
    rst = 1'b1; locked = 1'b0;
    // nominal lock
    add(1,0,2,   1,1,0,0,0,0);  add(0,0,3,   1,1,0,0,0,0);  add(0,0,1,   0,1,0,0,0,0);
    add(0,1,2,   0,1,0,0,0,0);  add(0,1,1,   0,1,0,0,0,0);  add(0,1,7,   0,1,0,0,0,0);
    add(0,1,1,   0,0,1,0,0,0);
    // loss of lock in RUN
    add(0,0,2,   0,0,1,0,0,0);  add(0,0,1,   1,1,0,0,0,1);
    // timeout retries to FAIL, then reset out of FAIL
    add(0,0,3,   1,1,0,0,0,1);  add(0,0,1,   0,1,0,0,0,1);  add(0,0,19,  0,1,0,0,0,1);
    add(0,0,1,   1,1,0,0,1,1);  add(0,0,4,   0,1,0,0,1,1);  add(0,0,20,  1,1,0,0,2,1);
    add(0,0,4,   0,1,0,0,2,1);  add(0,0,19,  0,1,0,0,2,1);  add(0,0,1,   1,1,0,1,2,1);
    add(0,0,100, 1,1,0,1,2,1);  add(1,0,1,   1,1,0,0,0,0);
    // reset mid-STABLE at cnt=5
    add(0,0,4,   0,1,0,0,0,0);  add(0,1,3,   0,1,0,0,0,0);  add(0,1,5,   0,1,0,0,0,0);
    add(1,1,1,   1,1,0,0,0,0);
    // lock glitch in STABLE
    add(0,0,4,   0,1,0,0,0,0);  add(0,1,3,   0,1,0,0,0,0);  add(0,1,2,   0,1,0,0,0,0);
    add(0,0,2,   0,1,0,0,0,0);  add(0,0,1,   0,1,0,0,0,0);  add(0,1,2,   0,1,0,0,0,0);
    add(0,1,1,   0,1,0,0,0,0);  add(0,1,7,   0,1,0,0,0,0);  add(0,1,1,   0,0,1,0,0,0);
    // lock seen on the timeout edge wins
    add(0,0,3,   1,1,0,0,0,1);  add(0,0,4,   0,1,0,0,0,1);  add(0,0,17,  0,1,0,0,0,1);
    add(0,1,2,   0,1,0,0,0,1);  add(0,1,1,   0,1,0,0,0,1);  add(0,1,7,   0,1,0,0,0,1);
    add(0,1,1,   0,0,1,0,0,1);
    // repeated losses
    add(0,0,3,   1,1,0,0,0,2);  add(0,0,4,   0,1,0,0,0,2);  add(0,1,3,   0,1,0,0,0,2);
    add(0,1,8,   0,0,1,0,0,2);  add(0,0,3,   1,1,0,0,0,3);

    for (int i = 0; i < tbl.size(); i++) begin
      repeat (tbl[i].n) cycle(tbl[i].r, tbl[i].lk);
      checks++;
      if (pll_rst !== tbl[i].pll || sys_rst !== tbl[i].sys || lock_ok !== tbl[i].ok ||
          fail !== tbl[i].fl || retry_cnt !== 4'(tbl[i].retry) || loss_cnt !== 16'(tbl[i].loss)) begin
        failures++;
        $display("FAIL tbl[%0d] got pll=%b sys=%b ok=%b fail=%b retry=%0d loss=%0d want pll=%b sys=%b ok=%b fail=%b retry=%0d loss=%0d",
                 i, pll_rst, sys_rst, lock_ok, fail, retry_cnt, loss_cnt,
                 tbl[i].pll, tbl[i].sys, tbl[i].ok, tbl[i].fl, tbl[i].retry, tbl[i].loss);
      end
    end

    // randomized lock runs with occasional resets
    for (int k = 0; k < 200; k++) begin
      bit lk;
      int n;
      lk = ($urandom_range(0, 9) < 7);
      n  = $urandom_range(1, 40);
      if ($urandom_range(0, 24) == 0) cycle(1'b1, lk);
      repeat (n) cycle(1'b0, lk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
